// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with two write ports (ALU write-back
// on port A, memory load-return on port B), optional write-to-read bypass,
// optional hardwired zero register and a pending-load scoreboard that flags
// source registers still waiting on a load.
module regfile_sb #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [AW-1:0]    src0_i,
  input  logic [AW-1:0]    src1_i,
  output logic [WIDTH-1:0] op0_o,
  output logic [WIDTH-1:0] op1_o,
  input  logic             wa_en_i,
  input  logic [AW-1:0]    wa_addr_i,
  input  logic [WIDTH-1:0] wa_data_i,
  input  logic             wb_en_i,
  input  logic [AW-1:0]    wb_addr_i,
  input  logic [WIDTH-1:0] wb_data_i,
  input  logic             ld_issue_i,
  input  logic [AW-1:0]    ld_addr_i,
  output logic             src0_busy_o,
  output logic             src1_busy_o,
  output logic             stall_o,
  output logic             wr_conflict_o
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             conflict_q;
  logic             conflict_d;

  logic             waValid;
  logic             wbValid;
  logic             ldValid;
  logic             wbCommit;

  logic [AW-1:0]    srcAddr [2];
  logic [WIDTH-1:0] opData  [2];

  // Accesses aimed at a hardwired zero register are treated as if they never
  // happened, so they neither write, collide nor mark the register busy.
  assign waValid = wa_en_i && !(ZERO_REG && (wa_addr_i == '0));
  assign wbValid = wb_en_i && !(ZERO_REG && (wb_addr_i == '0));
  assign ldValid = ld_issue_i && !(ZERO_REG && (ld_addr_i == '0));

  // Port A wins a same-address collision; the load-return data is dropped.
  assign conflict_d = waValid && wbValid && (wa_addr_i == wb_addr_i);
  assign wbCommit   = wbValid && !conflict_d;

  // Next-state of the storage array: port B first so port A overrides it.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      regs_d[r] = regs_q[r];
      if (wbCommit && (wb_addr_i == AW'(r))) regs_d[r] = wb_data_i;
      if (waValid && (wa_addr_i == AW'(r))) regs_d[r] = wa_data_i;
    end
  end

  // Scoreboard next-state: a new load outranks a return to the same register.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < DEPTH; r++) begin
      if (wbValid && (wb_addr_i == AW'(r))) busy_d[r] = 1'b0;
      if (ldValid && (ld_addr_i == AW'(r))) busy_d[r] = 1'b1;
    end
  end

  // State registers, cleared asynchronously by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= regs_d[r];
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign srcAddr[0] = src0_i;
  assign srcAddr[1] = src1_i;

  // Read ports: stored value, optionally overridden by same-cycle write data
  // with port A taking priority, and forced to zero for the zero register.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      opData[p] = regs_q[srcAddr[p]];
      if (BYPASS) begin
        if (wb_en_i && (wb_addr_i == srcAddr[p])) opData[p] = wb_data_i;
        if (wa_en_i && (wa_addr_i == srcAddr[p])) opData[p] = wa_data_i;
      end
      if (ZERO_REG && (srcAddr[p] == '0)) opData[p] = '0;
    end
  end

  assign op0_o         = opData[0];
  assign op1_o         = opData[1];
  assign src0_busy_o   = busy_q[src0_i];
  assign src1_busy_o   = busy_q[src1_i];
  assign stall_o       = src0_busy_o | src1_busy_o;
  assign wr_conflict_o = conflict_q;

endmodule
